// File: rtl/key_pkg.sv
// Shared key codes and encoder state type for the key-match input path.
package key_pkg;

  localparam logic [3:0] KEY_NONE  = 4'h0;
  localparam logic [3:0] KEY_UP    = 4'h1;
  localparam logic [3:0] KEY_DOWN  = 4'h2;
  localparam logic [3:0] KEY_LEFT  = 4'h3;
  localparam logic [3:0] KEY_RIGHT = 4'h4;
  localparam logic [3:0] KEY_END   = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } enc_state_t;

  // Maps a one-hot button vector to its key code; anything else is NONE.
  function automatic logic [3:0] encode_btn(input logic [3:0] btn);
    logic [3:0] code;
    code = KEY_NONE;
    case (btn)
      4'b0001: code = KEY_UP;
      4'b0010: code = KEY_DOWN;
      4'b0100: code = KEY_LEFT;
      4'b1000: code = KEY_RIGHT;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_input_encoder_debounce_bit.sv
// One button: 2-flop synchroniser, then a level is accepted only after it
// differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == btn_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Toggle on the edge the count would reach DEBOUNCE_CYCLES, so it never wraps.
        btn_stable <= ~btn_stable;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_input_encoder.sv
// Debounces four direction buttons and emits one latched key code per
// single-button press; multi-button presses are held off until full release.
module key_input_encoder
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  output logic [3:0] key_pressed,
  output logic       key_strobe,
  output logic [3:0] btn_stable
);

  enc_state_t state;
  enc_state_t state_nxt;
  logic [3:0] key_nxt;
  logic       strobe_nxt;
  logic       any_btn;
  logic       one_hot;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw[i]),
      .btn_stable(btn_stable[i])
    );
  end

  assign any_btn = |btn_stable;
  assign one_hot = any_btn && ((btn_stable & (btn_stable - 4'd1)) == 4'd0);

  always_comb begin
    state_nxt  = state;
    key_nxt    = key_pressed;
    strobe_nxt = 1'b0;
    case (state)
      IDLE: begin
        key_nxt = KEY_NONE;
        if (one_hot) begin
          state_nxt  = HELD;
          key_nxt    = encode_btn(btn_stable);
          strobe_nxt = 1'b1;
        end else if (any_btn) begin
          state_nxt = BLOCKED;
        end
      end
      HELD: begin
        // Code stays latched through roll-over until every button is up.
        if (!any_btn) begin
          state_nxt = IDLE;
          key_nxt   = KEY_NONE;
        end
      end
      BLOCKED: begin
        key_nxt = KEY_NONE;
        if (!any_btn) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        key_nxt   = KEY_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      key_pressed <= KEY_NONE;
      key_strobe  <= 1'b0;
    end else begin
      state       <= state_nxt;
      key_pressed <= key_nxt;
      key_strobe  <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_key_input_encoder.sv
// Directed bench for key_input_encoder with DEBOUNCE_CYCLES=4.
module tb_key_input_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] key_pressed;
  logic       key_strobe;
  logic [3:0] btn_stable;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int bad_code = 0;

  key_input_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .key_pressed(key_pressed),
    .key_strobe (key_strobe),
    .btn_stable (btn_stable)
  );

  always #5 clk = ~clk;

  // Strobes and illegal codes are tallied 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (key_strobe === 1'b1) strobe_cnt++;
    if (key_pressed > 4'd4) bad_code++;
  end

  typedef struct {
    logic [3:0] raw;
    int         edges;
    logic [3:0] stable;
    logic [3:0] key;
    logic       strobe;
    int         nstb;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n edges, then settle past the strobe monitor.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // raw, edges, stable, key, strobe, cumulative strobes
    // clean press LEFT
    vecs[0]  = '{4'h4, 5,  4'h0, 4'h0, 1'b0, 0};
    vecs[1]  = '{4'h4, 1,  4'h4, 4'h0, 1'b0, 0};
    vecs[2]  = '{4'h4, 1,  4'h4, 4'h3, 1'b1, 1};
    vecs[3]  = '{4'h4, 1,  4'h4, 4'h3, 1'b0, 1};
    vecs[4]  = '{4'h4, 16, 4'h4, 4'h3, 1'b0, 1};
    vecs[5]  = '{4'h0, 5,  4'h4, 4'h3, 1'b0, 1};
    vecs[6]  = '{4'h0, 1,  4'h0, 4'h3, 1'b0, 1};
    vecs[7]  = '{4'h0, 1,  4'h0, 4'h0, 1'b0, 1};
    // glitch reject on UP
    vecs[8]  = '{4'h1, 3,  4'h0, 4'h0, 1'b0, 1};
    vecs[9]  = '{4'h0, 2,  4'h0, 4'h0, 1'b0, 1};
    vecs[10] = '{4'h1, 3,  4'h0, 4'h0, 1'b0, 1};
    vecs[11] = '{4'h0, 10, 4'h0, 4'h0, 1'b0, 1};
    // multi-press then RIGHT alone
    vecs[12] = '{4'h3, 6,  4'h3, 4'h0, 1'b0, 1};
    vecs[13] = '{4'h3, 1,  4'h3, 4'h0, 1'b0, 1};
    vecs[14] = '{4'h0, 7,  4'h0, 4'h0, 1'b0, 1};
    vecs[15] = '{4'h8, 6,  4'h8, 4'h0, 1'b0, 1};
    vecs[16] = '{4'h8, 1,  4'h8, 4'h4, 1'b1, 2};
    vecs[17] = '{4'h0, 7,  4'h0, 4'h0, 1'b0, 2};
    // roll-over DOWN -> DOWN+RIGHT -> RIGHT -> none
    vecs[18] = '{4'h2, 7,  4'h2, 4'h2, 1'b1, 3};
    vecs[19] = '{4'h2, 3,  4'h2, 4'h2, 1'b0, 3};
    vecs[20] = '{4'hA, 7,  4'hA, 4'h2, 1'b0, 3};
    vecs[21] = '{4'h8, 7,  4'h8, 4'h2, 1'b0, 3};
    vecs[22] = '{4'h0, 6,  4'h0, 4'h2, 1'b0, 3};
    vecs[23] = '{4'h0, 1,  4'h0, 4'h0, 1'b0, 3};
    // repeat press LEFT
    vecs[24] = '{4'h4, 7,  4'h4, 4'h3, 1'b1, 4};
    vecs[25] = '{4'h0, 7,  4'h0, 4'h0, 1'b0, 4};
    vecs[26] = '{4'h0, 8,  4'h0, 4'h0, 1'b0, 4};
    vecs[27] = '{4'h4, 7,  4'h4, 4'h3, 1'b1, 5};
    vecs[28] = '{4'h0, 7,  4'h0, 4'h0, 1'b0, 5};

    reset   = 1'b1;
    btn_raw = 4'h0;
    #1;
    chk("rst_key", int'(key_pressed), 0);
    chk("rst_strobe", int'(key_strobe), 0);
    chk("rst_stable", int'(btn_stable), 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      btn_raw = vecs[i].raw;
      adv(vecs[i].edges);
      chk($sformatf("v%0d_stable", i), int'(btn_stable), int'(vecs[i].stable));
      chk($sformatf("v%0d_key", i), int'(key_pressed), int'(vecs[i].key));
      chk($sformatf("v%0d_strobe", i), int'(key_strobe), int'(vecs[i].strobe));
      chk($sformatf("v%0d_nstrobe", i), strobe_cnt, vecs[i].nstb);
    end

    // Reset mid-press: UP held across a 2-cycle reset pulse.
    btn_raw = 4'h1;
    adv(7);
    chk("mid_key_before", int'(key_pressed), 1);
    chk("mid_strobe_before", int'(key_strobe), 1);
    reset = 1'b1;
    #1;
    chk("mid_key_async", int'(key_pressed), 0);
    chk("mid_strobe_async", int'(key_strobe), 0);
    chk("mid_stable_async", int'(btn_stable), 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    adv(5);
    chk("mid_stable_e5", int'(btn_stable), 0);
    adv(1);
    chk("mid_stable_e6", int'(btn_stable), 1);
    chk("mid_key_e6", int'(key_pressed), 0);
    adv(1);
    chk("mid_key_e7", int'(key_pressed), 1);
    chk("mid_strobe_e7", int'(key_strobe), 1);
    chk("mid_nstrobe", strobe_cnt, 7);
    adv(1);
    chk("mid_strobe_e8", int'(key_strobe), 0);
    btn_raw = 4'h0;
    adv(7);
    chk("mid_release_key", int'(key_pressed), 0);
    chk("bad_code_seen", bad_code, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_input_encoder.md
# key_input_encoder

Upstream input stage for the key-match logic. Synchronises and debounces the four raw direction buttons and encodes them into the 4-bit `key_pressed` code the matcher consumes. Guarantees the matcher sees exactly one stable code per physical press, held until full release, and 0 otherwise. Multi-button presses are rejected.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a synchronised level must differ from the debounced level before it is accepted. Legal range is ≥1.
- `CNT_W`, default 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `btn_raw` in 4: asynchronous buttons, active-high. bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT.
- `key_pressed` out 4: accepted key code. 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT. Never drives 5–F.
- `key_strobe` out 1: one-cycle pulse on the cycle `key_pressed` goes from 0 to a non-zero code.
- `btn_stable` out 4: debounced button levels, for debug and LEDs.

## Operation
- **Synchroniser:** each `btn_raw` bit passes through a 2-flop synchroniser (`sync1`, `sync2`).
- **Debounce, per bit:**
  - Counter clears whenever `sync2 == stable`.
  - Otherwise it increments.
  - When the counter would reach `DEBOUNCE_CYCLES`, `stable` toggles and the counter clears on the same edge.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored, and the counter restarts from 0.
  - The counter never wraps.
- **Encoder FSM, states IDLE, HELD, BLOCKED:**
  - IDLE, `btn_stable == 0` → stay; `key_pressed = 0`.
  - IDLE, exactly one `btn_stable` bit set → HELD. Latch its code into `key_pressed` and assert `key_strobe` on the same edge.
  - IDLE, two or more bits set → BLOCKED; `key_pressed` stays 0.
  - HELD: `key_pressed` holds the latched code, even if other buttons are added or the original button is released while others remain. `btn_stable == 0` → IDLE and `key_pressed = 0` on that edge.
  - BLOCKED: `key_pressed = 0`. `btn_stable == 0` → IDLE.
- **Re-press:** a new key is accepted only after passing through IDLE with all buttons released. This matches the matcher's wait state, which waits for `key_pressed == 0`.
- **Reset values:** `key_pressed = 0`, `key_strobe = 0`, `btn_stable = 0`, state IDLE, synchronisers and counters 0.
- **Reset asserted mid-press:** all state clears. A button still held when reset deasserts is debounced afresh and treated as a new press.

## Timing
- Edge 1 is the first clock edge sampling a new `btn_raw` level, held steady.
- `sync2` updates at edge 2.
- `btn_stable` toggles at edge 2+`DEBOUNCE_CYCLES`.
- `key_pressed` and `key_strobe` update at edge 3+`DEBOUNCE_CYCLES`. All outputs are registered.
- `key_strobe` is high for exactly one cycle per accepted press.
- Release latency equals press latency.
- Simultaneous events:
  - Two bits reaching stable-high on the same edge count as a multi-press → BLOCKED.
  - A bit that stabilises one cycle after another, while in HELD, is ignored.

## Structure
- Shared package `key_pkg` holds:
  - Key-code localparams: `KEY_NONE=4'h0`, `KEY_UP=4'h1`, `KEY_DOWN=4'h2`, `KEY_LEFT=4'h3`, `KEY_RIGHT=4'h4`, `KEY_END=4'hF`.
  - Encoder state typedef `enc_state_t` {IDLE, HELD, BLOCKED}.
  - The sequence generator uses the same package for its code constants.
- Sub-module `debounce_bit` (params `DEBOUNCE_CYCLES`, `CNT_W`) contains the synchroniser, counter and stable flop. It is instantiated 4× via generate.
- Top level contains the one-hot check, encoder and FSM.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Clean press:** `btn_raw=4'b0100` from edge 1, held 20 cycles. Response: `btn_stable[2]` rises at edge 6; `key_pressed=3` and `key_strobe=1` at edge 7; strobe is 0 at edge 8. Release: `key_pressed=0` 7 edges after the release is first sampled.
- **Glitch reject:** `btn_raw[0]` high for 3 cycles, low, then high for 3 cycles. Response: `btn_stable` and `key_pressed` stay 0 throughout; no strobe.
- **Multi-press:** `btn_raw=4'b0011` applied at once. Response: state BLOCKED and `key_pressed=0`, no strobe. Release all, then press bit3 alone → `key_pressed=4` with one strobe.
- **Roll-over:** press DOWN, then add RIGHT 10 cycles later, then release DOWN. Response: `key_pressed` stays 2 throughout. Release RIGHT → 0. No second strobe.
- **Repeat press:** press/release LEFT twice with ≥8 idle cycles between. Response: two strobes, `key_pressed` sequence 3,0,3,0.
- **Reset mid-press:** UP held, `key_pressed=1`, then `reset` pulsed for 2 cycles while UP stays held. Response: all outputs 0 immediately (async). `key_pressed=1` and a strobe return at edge 7 after reset release.
